tile_pixel_fetcher: RTL and testbench
=====================================

TILE_PIXEL_FETCHER -- requirements
Module: tile_pixel_fetcher

Interface
REQ-001 Parameter TRANSPARENT_INDEX, default 4'h0: the colour index that drives pix_transparent high.
REQ-002 clk  in  1  single clock; all sequential logic on posedge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  1  a row-fetch request is present.
REQ-005 req_ready  out  1  the block accepts a request this cycle.
REQ-006 req_tile  in  11  tile index, 0..2047.
REQ-007 req_row  in  3  pixel row within the 8x8 tile, 0..7.
REQ-008 req_hflip  in  1  emit the row right-to-left.
REQ-009 req_palette  in  4  palette tag passed through to the pixels.
REQ-010 tile_addr  out  12  read address to the tile memory; equals {1'b0, tile}.
REQ-011 tile_data  in  256  combinational read data from the tile memory for tile_addr.
REQ-012 pix_valid  out  1  a pixel is presented.
REQ-013 pix_ready  in  1  the downstream stage takes the pixel.
REQ-014 pix_index  out  4  4bpp colour index.
REQ-015 pix_palette  out  4  latched req_palette.
REQ-016 pix_transparent  out  1  pix_index == TRANSPARENT_INDEX.
REQ-017 pix_last  out  1  the presented pixel is the 8th of the row.

Function
REQ-018 Tile layout: 256 bits hold 8 rows of 32 bits, MSB first; row r occupies tile_data[255-32r -: 32]; pixel x of that row occupies bits [31-4x -: 4] of the row slice.
REQ-019 The FSM has three states, IDLE, FETCH and SHIFT, and all state is registered.
REQ-020 In IDLE: req_ready=1 and pix_valid=0; on req_valid=1, latch row, hflip and palette, register tile_addr from req_tile, then go to FETCH.
REQ-021 In FETCH: req_ready=0 and pix_valid=0; capture the 32-bit slice of the latched row from tile_data into the row register, clear the pixel counter to 0, then go to SHIFT; FETCH lasts exactly one cycle.
REQ-022 In SHIFT: pix_valid=1 and req_ready=0.
REQ-023 In SHIFT, pix_index = pixel (hflip ? 7-cnt : cnt) of the row register.
REQ-024 In SHIFT, pix_last = (cnt == 7).
REQ-025 A pixel transfers when pix_valid and pix_ready are both 1; on each transfer cnt increments by 1.
REQ-026 A transfer while cnt == 7 returns the FSM to IDLE.
REQ-027 With pix_ready=0, all pixel outputs hold stable and cnt holds.
REQ-028 Latency: request accepted in cycle N gives pixel 0 valid in cycle N+2; with pix_ready held at 1, the last pixel is in cycle N+9 and req_ready=1 again in N+10.
REQ-029 The counter is 3 bits and never wraps inside a row; the exit at cnt==7 is the only terminal.
REQ-030 tile_addr changes only on request acceptance and otherwise holds its last value.
REQ-031 req_tile, req_row, req_hflip and req_palette are ignored outside the IDLE acceptance cycle.
REQ-032 req_valid is ignored while req_ready=0; no request is queued.
REQ-033 pix_palette is constant for the whole row and equals the value latched at acceptance.
REQ-034 pix_transparent is combinational from pix_index and is valid only while pix_valid=1.

Reset
REQ-035 reset_n=0 immediately and asynchronously forces state IDLE, cnt=0, row register=0, tile_addr=0, latched row/hflip/palette=0.
REQ-036 After reset: pix_valid=0, pix_index=0, pix_palette=0, pix_last=0, pix_transparent=1 (with default TRANSPARENT_INDEX).
REQ-037 After reset, req_ready=1 from the first cycle after reset_n rises.
REQ-038 Reset asserted during FETCH or SHIFT abandons the row; no partial pixel is emitted after release.

Verification
REQ-039 Tile 5, row 2, hflip=0, palette=3, tile_data row slice 32'h0123_4567, pix_ready=1 -> tile_addr=12'h005; indices 0,1,2,3,4,5,6,7 in cycles N+2..N+9; pix_last only on index 7; pix_palette=3; pix_transparent only on the first pixel.
REQ-040 Same request with hflip=1 -> indices 7,6,5,4,3,2,1,0; pix_last on the 8th pixel (index 0).
REQ-041 pix_ready toggles 1,0,0,1,... -> no pixel is lost or duplicated, outputs hold during stalls, and exactly 8 transfers occur.
REQ-042 req_valid held high for back-to-back requests to tile 2047 row 7 then tile 0 row 0 -> the second request is accepted only in the cycle after the last transfer of the first; tile_addr is 12'h7FF then 12'h000.
REQ-043 reset_n pulsed low during SHIFT at cnt=4 -> pix_valid=0 immediately, state returns to IDLE, req_ready=1 after release, and the next request produces a full row of 8 pixels starting at pixel 0.

Source files
------------

// File: rtl/tile_pixel_fetcher_if.sv
// Request, tile-memory and pixel-stream signals of the tile pixel fetcher.
interface tile_pixel_fetcher_if;
  logic         req_valid;
  logic         req_ready;
  logic [10:0]  req_tile;
  logic [2:0]   req_row;
  logic         req_hflip;
  logic [3:0]   req_palette;
  logic [11:0]  tile_addr;
  logic [255:0] tile_data;
  logic         pix_valid;
  logic         pix_ready;
  logic [3:0]   pix_index;
  logic [3:0]   pix_palette;
  logic         pix_transparent;
  logic         pix_last;

  // Environment side: issues requests, serves tile memory, consumes pixels.
  modport master (
    output req_valid, req_tile, req_row, req_hflip, req_palette, tile_data, pix_ready,
    input  req_ready, tile_addr, pix_valid, pix_index, pix_palette, pix_transparent, pix_last
  );

  // Fetcher side.
  modport slave (
    input  req_valid, req_tile, req_row, req_hflip, req_palette, tile_data, pix_ready,
    output req_ready, tile_addr, pix_valid, pix_index, pix_palette, pix_transparent, pix_last
  );
endinterface

// File: rtl/tile_pixel_fetcher.sv
// Fetches one 32-bit row of an 8x8 4bpp tile and streams its 8 pixels,
// optionally mirrored, with a palette tag and transparency flag.
module tile_pixel_fetcher #(
  parameter logic [3:0] TRANSPARENT_INDEX = 4'h0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  tile_pixel_fetcher_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT} state_t;

  state_t      state, state_next;
  logic [2:0]  cnt;
  logic [31:0] row_q;
  logic [11:0] addr_q;
  logic [2:0]  row_sel_q;
  logic        hflip_q;
  logic [3:0]  palette_q;

  logic [7:0]  row_msb;
  logic [2:0]  pix_sel;
  logic [4:0]  pix_msb;
  logic        xfer;

  assign row_msb = 8'd255 - {row_sel_q, 5'b0};
  assign pix_sel = hflip_q ? (3'd7 - cnt) : cnt;
  assign pix_msb = 5'd31 - {pix_sel, 2'b00};
  assign xfer    = (state == SHIFT) && bus.pix_ready;

  assign bus.tile_addr       = addr_q;
  assign bus.pix_palette     = palette_q;
  assign bus.pix_transparent = (bus.pix_index == TRANSPARENT_INDEX);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state and handshake/pixel outputs.
  always_comb begin
    state_next    = state;
    bus.req_ready = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_index = '0;
    bus.pix_last  = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_next = FETCH;
      end
      FETCH: state_next = SHIFT;
      SHIFT: begin
        bus.pix_valid = 1'b1;
        bus.pix_index = row_q[pix_msb -: 4];
        bus.pix_last  = (cnt == 3'd7);
        if (bus.pix_ready && cnt == 3'd7) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latching, row capture and pixel counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      row_q     <= '0;
      addr_q    <= '0;
      row_sel_q <= '0;
      hflip_q   <= 1'b0;
      palette_q <= '0;
    end else begin
      if (state == IDLE && bus.req_valid) begin
        row_sel_q <= bus.req_row;
        hflip_q   <= bus.req_hflip;
        palette_q <= bus.req_palette;
        addr_q    <= {1'b0, bus.req_tile};
      end
      if (state == FETCH) begin
        row_q <= bus.tile_data[row_msb -: 32];
        cnt   <= '0;
      end
      // Counter saturates at 7; the transfer at 7 leaves SHIFT instead.
      if (xfer && cnt != 3'd7) cnt <= cnt + 3'd1;
    end
  end

endmodule

// File: tb/tb_tile_pixel_fetcher.sv
// Self-checking bench for tile_pixel_fetcher: table-driven row requests with a
// pixel scoreboard, plus back-to-back and mid-row reset sequences.
module tb_tile_pixel_fetcher;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  tile_pixel_fetcher_if bus();

  tile_pixel_fetcher #(.TRANSPARENT_INDEX(4'h0)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Tile memory model: one fixed row for the reference pattern, hashed otherwise.
  function automatic logic [31:0] mem_row(input logic [11:0] a, input int unsigned r);
    logic [31:0] h;
    if (a == 12'h005 && r == 2) return 32'h0123_4567;
    h = (32'(a) * 32'd8 + 32'(r) + 32'd1) * 32'h9E37_79B9;
    return h ^ (h >> 13);
  endfunction

  function automatic logic [255:0] mem_tile(input logic [11:0] a);
    logic [255:0] t;
    t = '0;
    for (int unsigned r = 0; r < 8; r++) t = (t << 32) | 256'(mem_row(a, r));
    return t;
  endfunction

  assign bus.tile_data = mem_tile(bus.tile_addr);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // pix_ready pattern: mode 0 always ready, mode 1 repeats 1,0,0.
  int mode = 0;
  int unsigned phase = 0;
  initial begin
    bus.pix_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      if (mode == 0) bus.pix_ready = 1'b1;
      else bus.pix_ready = (phase == 0);
      phase = (phase + 1) % 3;
    end
  end

  typedef struct {
    logic [3:0] idx;
    logic       last;
    logic [3:0] pal;
  } exp_t;
  exp_t q[$];

  int accepts = 0;
  int acc_cyc = 0;
  int last_cyc = 0;
  int xfers = 0;
  bit row_done = 0;
  bit addr_pending = 0;
  logic [11:0] exp_addr_m;
  bit prev_valid = 0;
  bit stall_prev = 0;
  logic [3:0] p_idx, p_pal;
  logic p_last, p_trans;

  // Monitor: acceptance pushes the expected row; each transfer pops and compares.
  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
      prev_valid = 0;
      stall_prev = 0;
      addr_pending = 0;
    end else begin
      if (addr_pending) begin
        check("tile_addr_latch", 32'(bus.tile_addr), 32'(exp_addr_m));
        addr_pending = 0;
      end
      if (bus.pix_valid && !prev_valid)
        check("first_pix_latency", 32'(cyc), 32'(acc_cyc + 2));
      if (stall_prev) begin
        check("stall_valid", 32'(bus.pix_valid), 32'd1);
        check("stall_index", 32'(bus.pix_index), 32'(p_idx));
        check("stall_last", 32'(bus.pix_last), 32'(p_last));
        check("stall_palette", 32'(bus.pix_palette), 32'(p_pal));
        check("stall_transp", 32'(bus.pix_transparent), 32'(p_trans));
      end
      if (bus.pix_valid && bus.pix_ready) begin
        if (q.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("pix_index", 32'(bus.pix_index), 32'(e.idx));
          check("pix_last", 32'(bus.pix_last), 32'(e.last));
          check("pix_palette", 32'(bus.pix_palette), 32'(e.pal));
          check("pix_transparent", 32'(bus.pix_transparent), 32'(e.idx == 4'h0));
        end
        xfers++;
        if (bus.pix_last) begin
          row_done = 1;
          last_cyc = cyc;
        end
      end
      if (bus.req_valid && bus.req_ready) begin
        logic [31:0] s;
        s = mem_row({1'b0, bus.req_tile}, int'(bus.req_row));
        for (int unsigned k = 0; k < 8; k++) begin
          exp_t e;
          int unsigned x;
          x = bus.req_hflip ? 7 - k : k;
          e.idx  = 4'((s >> (28 - 4 * x)) & 32'hF);
          e.last = (k == 7);
          e.pal  = bus.req_palette;
          q.push_back(e);
        end
        exp_addr_m = {1'b0, bus.req_tile};
        addr_pending = 1;
        acc_cyc = cyc;
        accepts++;
        xfers = 0;
        row_done = 0;
      end
      prev_valid = bus.pix_valid;
      stall_prev = bus.pix_valid && !bus.pix_ready;
      p_idx = bus.pix_index;
      p_pal = bus.pix_palette;
      p_last = bus.pix_last;
      p_trans = bus.pix_transparent;
    end
  end

  typedef struct {
    logic [10:0] tile;
    logic [2:0]  row;
    logic        hflip;
    logic [3:0]  pal;
    int          rmode;
    logic [11:0] exp_addr;
  } vec_t;

  task automatic wait_accepts(input int target, input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (accepts >= target) begin ok = 1; break; end
    end
    check("accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_row(input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (row_done) begin ok = 1; break; end
      @(posedge clk); #2;
    end
    check("row_timeout", 32'(ok), 32'd1);
  endtask

  task automatic drive_req(input logic [10:0] t, input logic [2:0] r, input logic h, input logic [3:0] p);
    bus.req_tile = t;
    bus.req_row = r;
    bus.req_hflip = h;
    bus.req_palette = p;
    bus.req_valid = 1'b1;
  endtask

  task automatic do_request(input vec_t v);
    int a0;
    a0 = accepts;
    mode = v.rmode;
    @(posedge clk); #2;
    drive_req(v.tile, v.row, v.hflip, v.pal);
    wait_accepts(a0 + 1, 20);
    bus.req_valid = 1'b0;
    bus.req_tile = 11'($urandom);
    bus.req_row = 3'($urandom);
    bus.req_hflip = 1'($urandom);
    bus.req_palette = 4'($urandom);
    wait_row(80);
    check("row_xfers", 32'(xfers), 32'd8);
    check("sb_empty", 32'(q.size()), 32'd0);
    check("tile_addr_hold", 32'(bus.tile_addr), 32'(v.exp_addr));
    check("ready_after_row", 32'(bus.req_ready), 32'd1);
    if (v.rmode == 0) check("last_latency", 32'(last_cyc), 32'(acc_cyc + 9));
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{tile: 11'd5,    row: 3'd2, hflip: 1'b0, pal: 4'd3,  rmode: 0, exp_addr: 12'h005};
    vecs[1] = '{tile: 11'd5,    row: 3'd2, hflip: 1'b1, pal: 4'd3,  rmode: 0, exp_addr: 12'h005};
    vecs[2] = '{tile: 11'd5,    row: 3'd2, hflip: 1'b0, pal: 4'd3,  rmode: 1, exp_addr: 12'h005};
    vecs[3] = '{tile: 11'd1234, row: 3'd5, hflip: 1'b1, pal: 4'd9,  rmode: 1, exp_addr: 12'h4D2};
    vecs[4] = '{tile: 11'd2047, row: 3'd0, hflip: 1'b0, pal: 4'd15, rmode: 0, exp_addr: 12'h7FF};

    bus.req_valid = 1'b0;
    bus.req_tile = '0;
    bus.req_row = '0;
    bus.req_hflip = 1'b0;
    bus.req_palette = '0;

    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    check("rst_pix_valid", 32'(bus.pix_valid), 32'd0);
    check("rst_pix_index", 32'(bus.pix_index), 32'd0);
    check("rst_pix_palette", 32'(bus.pix_palette), 32'd0);
    check("rst_pix_last", 32'(bus.pix_last), 32'd0);
    check("rst_pix_transp", 32'(bus.pix_transparent), 32'd1);
    check("rst_tile_addr", 32'(bus.tile_addr), 32'd0);
    @(posedge clk); #2;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);

    for (int i = 0; i < 5; i++) do_request(vecs[i]);

    // Back-to-back requests with req_valid held high throughout.
    begin
      int a0;
      a0 = accepts;
      mode = 0;
      @(posedge clk); #2;
      drive_req(11'd2047, 3'd7, 1'b0, 4'd1);
      wait_accepts(a0 + 1, 20);
      check("b2b_addr_first", 32'(bus.tile_addr), 32'h7FF);
      drive_req(11'd0, 3'd0, 1'b0, 4'd2);
      wait_accepts(a0 + 2, 40);
      check("b2b_accept_cycle", 32'(acc_cyc), 32'(last_cyc + 1));
      check("b2b_addr_second", 32'(bus.tile_addr), 32'h000);
      bus.req_valid = 1'b0;
      wait_row(80);
      check("b2b_row_xfers", 32'(xfers), 32'd8);
      check("b2b_sb_empty", 32'(q.size()), 32'd0);
    end

    // Reset pulsed mid-row with the pixel counter at 4.
    begin
      int a0;
      bit ok;
      a0 = accepts;
      mode = 0;
      @(posedge clk); #2;
      drive_req(11'd77, 3'd3, 1'b0, 4'd6);
      wait_accepts(a0 + 1, 20);
      bus.req_valid = 1'b0;
      ok = 0;
      for (int i = 0; i < 20; i++) begin
        if (xfers >= 4) begin ok = 1; break; end
        @(posedge clk); #2;
      end
      check("mid_row_reach", 32'(ok), 32'd1);
      #1 reset_n = 1'b0;
      #1;
      check("midrst_pix_valid", 32'(bus.pix_valid), 32'd0);
      check("midrst_req_ready", 32'(bus.req_ready), 32'd1);
      check("midrst_pix_last", 32'(bus.pix_last), 32'd0);
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b1;
      check("postrst_req_ready", 32'(bus.req_ready), 32'd1);
      @(posedge clk); #2;
      check("postrst_pix_valid", 32'(bus.pix_valid), 32'd0);
      do_request(vecs[0]);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
